// File: rtl/ripple_carry_adder_4bit_gate.sv
// 4-bit gate-level ripple-carry adder with registered sum, carry-out and signed overflow.
// Latency 1 cycle; no backpressure, one operation accepted every cycle in_valid is high.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  wire p;
  wire g;
  wire t;

  xor u_p  (p, a, b);
  xor u_s  (s, p, ci);
  and u_g  (g, a, b);
  and u_t  (t, p, ci);
  or  u_co (co, g, t);
endmodule

module ripple_carry_adder_4bit_gate (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       overflow,
  output logic       out_valid
);
  wire [4:0] c;
  wire [3:0] s_core;
  wire       ov_core;

  assign c[0] = cin;

  // Carry ripples strictly from bit 0 to bit 3 through explicit nets c[1..4].
  for (genvar i = 0; i < 4; i++) begin : g_stage
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_core[i]),
      .co (c[i+1])
    );
  end

  xor u_ov (ov_core, c[3], c[4]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= 4'h0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s_core;
        cout     <= c[4];
        overflow <= ov_core;
      end
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder_4bit_gate.sv
// Directed and exhaustive check of the registered 4-bit ripple-carry adder.
module tb_ripple_carry_adder_4bit_gate;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       overflow;
  logic       out_valid;

  int checks = 0;
  int passes = 0;

  ripple_carry_adder_4bit_gate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus on the falling edge, then sample 1ns after the next rising edge.
  task automatic step(input logic rn, input logic v, input logic [3:0] ta,
                      input logic [3:0] tb, input logic tc);
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] es, input logic ec,
                            input logic eo, input logic ev);
    check({tag, ".sum"}, {4'h0, sum}, {4'h0, es});
    check({tag, ".cout"}, {7'h0, cout}, {7'h0, ec});
    check({tag, ".ovf"}, {7'h0, overflow}, {7'h0, eo});
    check({tag, ".vld"}, {7'h0, out_valid}, {7'h0, ev});
  endtask

  initial begin
    logic [4:0] ref_full;
    int         ssum;
    logic       ref_ov;

    rst_n = 1'b0; in_valid = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 4'b0001, 4'b0010, 1'b0);
    expect_out("1+2", 4'b0011, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 4'b0101, 4'b0111, 1'b0);
    expect_out("5+7", 4'b1100, 1'b0, 1'b1, 1'b1);

    step(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0);
    expect_out("f+1", 4'b0000, 1'b1, 1'b0, 1'b1);

    step(1'b1, 1'b1, 4'b1010, 4'b0101, 1'b1);
    expect_out("a+5+1", 4'b0000, 1'b1, 1'b0, 1'b1);

    step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    expect_out("0+0", 4'h0, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 4'b0110, 4'b0011, 1'b0);
    expect_out("6+3", 4'b1001, 1'b0, 1'b1, 1'b1);

    // Idle cycles with moving operands must leave the last result untouched.
    step(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1);
    expect_out("hold0", 4'b1001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0);
    expect_out("hold1", 4'b1001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b1);
    expect_out("hold2", 4'b1001, 1'b0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
    expect_out("rst_vs_vld", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    expect_out("f+f+1", 4'b1111, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] vec;
      vec      = 9'(i);
      ref_full = {1'b0, vec[7:4]} + {1'b0, vec[3:0]} + {4'h0, vec[8]};
      ssum     = int'($signed(vec[7:4])) + int'($signed(vec[3:0])) + int'(vec[8]);
      ref_ov   = (ssum > 7) || (ssum < -8);
      step(1'b1, 1'b1, vec[7:4], vec[3:0], vec[8]);
      expect_out("sweep", ref_full[3:0], ref_full[4], ref_ov, 1'b1);
    end

    step(1'b1, 1'b0, 4'h3, 4'h4, 1'b0);
    expect_out("post_sweep_hold", 4'hF, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder_4bit_gate.md
Name: ripple_carry_adder_4bit_gate

Overview:
- 4-bit unsigned/two's-complement adder with carry-in.
- Arithmetic core is built structurally from gate primitives as four chained full-adder stages (ripple carry).
- Results are captured in an output register stage with a valid flag, so the block drops into the synchronous datapath with one-cycle latency.

Parameters:
- None. Operand width is fixed at 4 bits.

Ports:
clk        input   1  system clock; all state updates on rising edge
rst_n      input   1  synchronous reset, active-low
in_valid   input   1  qualifies a, b, cin this cycle
a          input   4  operand A
b          input   4  operand B
cin        input   1  carry-in to bit 0
sum        output  4  registered sum bits [3:0]
cout       output  1  registered carry-out of bit 3
overflow   output  1  registered signed overflow (carry into bit 3 XOR carry out of bit 3)
out_valid  output  1  high for one cycle when sum/cout/overflow hold a new result

Behaviour:
- Core is purely combinational and structural: one full-adder cell per bit.
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c_0 = cin; c_4 is the raw carry-out.
  - Cells use gate primitives or equivalent bitwise expressions. No behavioural '+' operator anywhere in the core.
- Carry ripples strictly bit 0 -> bit 3. The internal carries c_1..c_4 are explicit nets.
- Arithmetic identity: {cout, sum} = a + b + cin, over the 5-bit range 0..31.
- overflow = c_3 ^ c_4, i.e. signed two's-complement overflow of a + b + cin.
- Register stage, evaluated on every rising clk edge:
  - rst_n == 0: sum = 4'h0, cout = 0, overflow = 0, out_valid = 0. Reset takes priority over in_valid.
  - rst_n == 1 and in_valid == 1: sum, cout and overflow load the core results; out_valid = 1.
  - rst_n == 1 and in_valid == 0: sum, cout and overflow hold their previous values; out_valid = 0.
- Latency is exactly 1 clock from sampled inputs to registered outputs. Throughput is one operation per cycle; back-to-back in_valid is allowed.
- Reset asserted in the same cycle as in_valid discards that operation. Outputs read zero and out_valid is 0 on the following cycle.
- Inputs changing between clock edges have no effect on the outputs. Only values present at the rising edge are sampled.
- No X propagation from the register stage after the first reset cycle. Outputs before the first reset edge are undefined.
- Boundary conditions:
  - a = 4'hF, b = 4'hF, cin = 1 gives sum = 4'hF, cout = 1.
  - a = b = 0, cin = 0 gives sum = 0, cout = 0, overflow = 0.

Test Plan:
- Reset, then a=0001, b=0010, cin=0, in_valid=1 -> next cycle: sum=0011, cout=0, overflow=0, out_valid=1.
- a=0101, b=0111, cin=0 -> sum=1100, cout=0, overflow=1 (signed 5+7 exceeds +7).
- a=1111, b=0001, cin=0 -> sum=0000, cout=1, overflow=0 (full carry ripple through all four stages). Then a=1010, b=0101, cin=1 -> sum=0000, cout=1, overflow=0.
- After a valid result, drive in_valid=0 with changed operands for 3 cycles -> sum, cout and overflow hold the prior values; out_valid=0 on each of those cycles.
- Assert rst_n=0 together with in_valid=1, a=1111, b=1111, cin=1 -> next cycle: all outputs 0. Release reset and re-apply the same operands -> sum=1111, cout=1, overflow=0.
- Exhaustive sweep of all 512 (a, b, cin) combinations with in_valid=1 every cycle -> each result matches a+b+cin with one-cycle latency, and overflow matches the signed overflow of the same sum.
